// File: rtl/bus_arbiter_if.sv
// Shared-bus request/grant bundle between the bus masters and the arbiter.
// All request and grant lines are active-low.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2
);
    logic [NUM_MASTERS-1:0] m_req_;
    logic [NUM_MASTERS-1:0] m_grnt_;
    logic [IDX_W-1:0]       owner;
    logic                   bus_idle;

    modport master (output m_req_, input m_grnt_, owner, bus_idle);
    modport slave  (input m_req_, output m_grnt_, owner, bus_idle);
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin owner-hold arbiter for the shared system bus, with a sticky watchdog
// that flags an owner holding the bus too long while other masters wait.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int IDX_W       = 2,
    parameter int MAX_HOLD    = 256,
    parameter int CNT_W       = 9
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.slave   bus,
    input  logic           err_clr,
    output logic           hold_err
);
    typedef enum logic {IDLE, OWNED} state_t;

    state_t                 state;
    logic [NUM_MASTERS-1:0] grnt_q;
    logic [IDX_W-1:0]       owner_q;
    logic [IDX_W-1:0]       rr_ptr;
    logic                   idle_q;
    logic [CNT_W-1:0]       hold_cnt;

    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W-1:0]       pick_next;
    logic [NUM_MASTERS-1:0] pick_grnt;
    logic                   others_wait;
    logic                   owner_release;
    logic                   cnt_inc;
    logic                   err_set;

    // Circular search starting at rr_ptr; the first low request wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            automatic int idx = (int'(rr_ptr) + k) % NUM_MASTERS;
            if (!found && !bus.m_req_[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        pick_grnt   = '1;
        others_wait = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (IDX_W'(i) == pick)
                pick_grnt[i] = 1'b0;
            if (IDX_W'(i) != owner_q && !bus.m_req_[i])
                others_wait = 1'b1;
        end
    end

    assign pick_next     = (pick == IDX_W'(NUM_MASTERS - 1)) ? '0 : pick + 1'b1;
    assign owner_release = (state == OWNED) && bus.m_req_[owner_q];
    assign cnt_inc       = (state == OWNED) && !owner_release && others_wait
                           && (hold_cnt != {CNT_W{1'b1}});
    assign err_set       = cnt_inc && (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // NOTE: the asynchronous reset is in the sensitivity list so grants drop without a clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            grnt_q   <= '1;
            owner_q  <= '0;
            rr_ptr   <= '0;
            idle_q   <= 1'b1;
            hold_cnt <= '0;
            hold_err <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (found) begin
                        state   <= OWNED;
                        grnt_q  <= pick_grnt;
                        owner_q <= pick;
                        rr_ptr  <= pick_next;
                        idle_q  <= 1'b0;
                    end
                end
                OWNED: begin
                    if (owner_release) begin
                        hold_cnt <= '0;
                        if (found) begin
                            grnt_q  <= pick_grnt;
                            owner_q <= pick;
                            rr_ptr  <= pick_next;
                        end else begin
                            state  <= IDLE;
                            grnt_q <= '1;
                            idle_q <= 1'b1;
                        end
                    end else if (cnt_inc) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Set has priority over clear on the same edge.
            if (err_set)
                hold_err <= 1'b1;
            else if (err_clr)
                hold_err <= 1'b0;
        end
    end

    assign bus.m_grnt_  = grnt_q;
    assign bus.owner    = owner_q;
    assign bus.bus_idle = idle_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: a vector table plus hand sequences for
// round-robin order, hold watchdog and asynchronous reset, checked via a scoreboard.
module tb_bus_arbiter;
    localparam int N = 4;

    typedef struct {
        logic [N-1:0] req;
        logic         clr;
        logic [N-1:0] grnt;
        logic [1:0]   own;
        logic         idle;
        logic         err;
    } vec_t;

    typedef struct {
        logic [N-1:0] grnt;
        logic [1:0]   own;
        logic         idle;
        logic         err;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic err_clr = 1'b0;
    logic hold_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    bus_arbiter_if #(.NUM_MASTERS(N), .IDX_W(2)) bus ();

    bus_arbiter #(
        .NUM_MASTERS(N),
        .IDX_W      (2),
        .MAX_HOLD   (8),
        .CNT_W      (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .err_clr (err_clr),
        .hold_err(hold_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare_now(input exp_t e);
        check({e.name, " grnt"},  32'(bus.m_grnt_), 32'(e.grnt));
        check({e.name, " owner"}, 32'(bus.owner),   32'(e.own));
        check({e.name, " idle"},  32'(bus.bus_idle), 32'(e.idle));
        check({e.name, " err"},   32'(hold_err),    32'(e.err));
        check({e.name, " onehot"}, 32'($countones(~bus.m_grnt_) <= 1), 32'd1);
    endtask

    // Drive inputs, queue the expectation, then compare one edge later.
    task automatic apply(input logic [N-1:0] req, input logic clr, input logic [N-1:0] g,
                         input logic [1:0] o, input logic i, input logic e, input string name);
        exp_t x;
        bus.m_req_ = req;
        err_clr    = clr;
        x = '{grnt: g, own: o, idle: i, err: e, name: name};
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            compare_now(x);
        end
    endtask

    vec_t vecs[8];

    initial begin
        int cur;
        logic [N-1:0] rq;

        vecs[0] = '{req: 4'b1110, clr: 1'b0, grnt: 4'b1110, own: 2'd0, idle: 1'b0, err: 1'b0};
        vecs[1] = '{req: 4'b1110, clr: 1'b0, grnt: 4'b1110, own: 2'd0, idle: 1'b0, err: 1'b0};
        vecs[2] = '{req: 4'b1011, clr: 1'b0, grnt: 4'b1011, own: 2'd2, idle: 1'b0, err: 1'b0};
        vecs[3] = '{req: 4'b1111, clr: 1'b0, grnt: 4'b1111, own: 2'd2, idle: 1'b1, err: 1'b0};
        vecs[4] = '{req: 4'b0110, clr: 1'b0, grnt: 4'b0111, own: 2'd3, idle: 1'b0, err: 1'b0};
        vecs[5] = '{req: 4'b0110, clr: 1'b0, grnt: 4'b0111, own: 2'd3, idle: 1'b0, err: 1'b0};
        vecs[6] = '{req: 4'b1111, clr: 1'b0, grnt: 4'b1111, own: 2'd3, idle: 1'b1, err: 1'b0};
        vecs[7] = '{req: 4'b1101, clr: 1'b0, grnt: 4'b1101, own: 2'd1, idle: 1'b0, err: 1'b0};

        bus.m_req_ = '1;
        #12;
        compare_now('{grnt: 4'b1111, own: 2'd0, idle: 1'b1, err: 1'b0, name: "reset"});
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Grant latency, handover without idle, release to idle, rr-ordered pick.
        foreach (vecs[k])
            apply(vecs[k].req, vecs[k].clr, vecs[k].grnt, vecs[k].own,
                  vecs[k].idle, vecs[k].err, $sformatf("vec%0d", k));

        // Owner 1 holds while master 3 waits: watchdog fires on the 8th waiting edge.
        for (int c = 1; c <= 7; c++)
            apply(4'b0101, 1'b0, 4'b1101, 2'd1, 1'b0, 1'b0, $sformatf("hold%0d", c));
        apply(4'b0101, 1'b0, 4'b1101, 2'd1, 1'b0, 1'b1, "hold8");
        apply(4'b0101, 1'b0, 4'b1101, 2'd1, 1'b0, 1'b1, "hold_sticky");
        apply(4'b0101, 1'b1, 4'b1101, 2'd1, 1'b0, 1'b0, "hold_clr");
        apply(4'b0101, 1'b0, 4'b1101, 2'd1, 1'b0, 1'b0, "hold_after_clr");

        // Full round-robin from reset with everyone requesting.
        rst = 1'b0;
        bus.m_req_ = '1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(4'b0000, 1'b0, 4'b1110, 2'd0, 1'b0, 1'b0, "rr_first");
        cur = 0;
        for (int r = 0; r < N; r++) begin
            apply(4'b0000, 1'b0, ~(4'b0001 << cur), 2'(cur), 1'b0, 1'b0, $sformatf("rr_hold%0d_a", r));
            apply(4'b0000, 1'b0, ~(4'b0001 << cur), 2'(cur), 1'b0, 1'b0, $sformatf("rr_hold%0d_b", r));
            rq = 4'b0001 << cur;
            cur = (cur + 1) % N;
            apply(rq, 1'b0, ~(4'b0001 << cur), 2'(cur), 1'b0, 1'b0, $sformatf("rr_move%0d", r));
        end

        // Asynchronous reset between edges while master 0 owns the bus.
        #2;
        rst = 1'b0;
        #1;
        compare_now('{grnt: 4'b1111, own: 2'd0, idle: 1'b1, err: 1'b0, name: "async_rst"});
        @(posedge clk);
        #1;
        rst = 1'b1;
        apply(4'b0000, 1'b0, 4'b1110, 2'd0, 1'b0, 1'b0, "post_rst_grant");

        check("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
